fnv_mix_ctrl: RTL and testbench

FNV_MIX_CTRL -- requirements
Module: fnv_mix_ctrl

---
 rtl/fnv_mix_ctrl_pkg.sv | 30 +++
 rtl/fnv_mix_ctrl_if.sv | 36 +++
 rtl/fnv_lane4.sv | 20 ++
 rtl/fnv_mix_ctrl.sv | 147 ++++++++++++++
 tb/tb_fnv_mix_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fnv_mix_ctrl_pkg.sv
// rtl/fnv_mix_ctrl_pkg.sv - shared Ethash constants, FSM state type and FNV helper
// Optional CMIX state is present only when FNV_CMIX_EN is defined.
package fnv_mix_ctrl_pkg;

  localparam int UINT32_BIT = 32;
  localparam int DAG_LANES  = 4;
  localparam logic [UINT32_BIT-1:0] FNV_PRIME = 32'h01000193;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
`ifdef FNV_CMIX_EN
    ST_CMIX,
`endif
    ST_DONE
  } fsm_state_e;

  function automatic int mix_words(input int num_beats);
    return 4 * num_beats;
  endfunction

  function automatic logic [UINT32_BIT-1:0] fnv32(input logic [UINT32_BIT-1:0] a,
                                                  input logic [UINT32_BIT-1:0] b);
    logic [UINT32_BIT-1:0] prod;
    prod = a * FNV_PRIME;
    return prod ^ b;
  endfunction

endpackage

// File: rtl/fnv_mix_ctrl_if.sv
// rtl/fnv_mix_ctrl_if.sv - start/DAG handshake and result bus of the mix controller
// cmix_out exists only when FNV_CMIX_EN is defined.
interface fnv_mix_ctrl_if import fnv_mix_ctrl_pkg::*; #(
  parameter int NUM_BEATS = 8,
  parameter int MIX_WORDS = mix_words(NUM_BEATS)
) ();

  logic                              start;
  logic [UINT32_BIT*MIX_WORDS-1:0]   mix_in;
  logic                              dag_valid;
  logic [UINT32_BIT*DAG_LANES-1:0]   dag_data;
  logic                              dag_ready;
  logic                              busy;
  logic                              done;
  logic [UINT32_BIT*MIX_WORDS-1:0]   mix_out;
`ifdef FNV_CMIX_EN
  logic [8*MIX_WORDS-1:0]            cmix_out;
`endif

  modport master (
    output start, mix_in, dag_valid, dag_data,
`ifdef FNV_CMIX_EN
    input  cmix_out,
`endif
    input  dag_ready, busy, done, mix_out
  );

  modport slave (
    input  start, mix_in, dag_valid, dag_data,
`ifdef FNV_CMIX_EN
    output cmix_out,
`endif
    output dag_ready, busy, done, mix_out
  );

endinterface

// File: rtl/fnv_lane4.sv
// rtl/fnv_lane4.sv - four parallel 32-bit FNV lanes with a registered result
module fnv_lane4 import fnv_mix_ctrl_pkg::*; (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DAG_LANES-1:0][UINT32_BIT-1:0] a,
  input  logic [DAG_LANES-1:0][UINT32_BIT-1:0] b,
  output logic [DAG_LANES-1:0][UINT32_BIT-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int j = 0; j < DAG_LANES; j++) begin
        q[j] <= fnv32(a[j], b[j]);
      end
    end
  end

endmodule

// File: rtl/fnv_mix_ctrl.sv
// rtl/fnv_mix_ctrl.sv - streams DAG beats through one 4-lane FNV unit to update the mix
// Defining FNV_CMIX_EN adds the CMIX compression pass and the cmix_out port.
module fnv_mix_ctrl import fnv_mix_ctrl_pkg::*; #(
  parameter int NUM_BEATS = 8,
  parameter int MIX_WORDS = mix_words(NUM_BEATS)
) (
  input  logic clk,
  input  logic rst,
  fnv_mix_ctrl_if.slave bus
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  fsm_state_e state_q, state_d;
  logic [CNT_W-1:0]                      beat_q;
  logic [MIX_WORDS-1:0][UINT32_BIT-1:0]  mix_q;
  logic [DAG_LANES-1:0][UINT32_BIT-1:0]  dag_lanes, lane_a, lane_b, lane_q;
  logic                                  wr_mix_q;
  logic [CNT_W-1:0]                      wr_beat_q;
  logic                                  accept;

`ifdef FNV_CMIX_EN
  localparam int HALVES = NUM_BEATS / DAG_LANES;
  localparam int HALF_W = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(HALVES - 1);

  logic [NUM_BEATS-1:0][UINT32_BIT-1:0] cmix_q;
  logic [1:0]                           cm_step_q;  // 1..3 issuing, 0 = drain cycle
  logic [HALF_W-1:0]                    cm_half_q;
  logic                                 wr_cmix_q;
  logic [HALF_W-1:0]                    wr_half_q;
`endif

  assign dag_lanes     = bus.dag_data;
  assign bus.dag_ready = (state_q == ST_RUN) && !rst;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.mix_out   = mix_q;
  assign accept        = bus.dag_valid && bus.dag_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (accept && beat_q == LAST_BEAT) state_d = ST_DRAIN;
`ifdef FNV_CMIX_EN
      ST_DRAIN: state_d = ST_CMIX;
      ST_CMIX:  if (cm_step_q == 2'd0) state_d = ST_DONE;
`else
      ST_DRAIN: state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Lane operand select: beat k in RUN, group compression steps in CMIX.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int j = 0; j < DAG_LANES; j++) begin
      if (state_q == ST_RUN) begin
        lane_a[j] = mix_q[{beat_q, 2'(j)}];
        lane_b[j] = dag_lanes[j];
      end
`ifdef FNV_CMIX_EN
      else if (state_q == ST_CMIX) begin
        lane_a[j] = (cm_step_q == 2'd1) ? mix_q[{cm_half_q, 2'(j), 2'd0}]
                                        : cmix_q[{cm_half_q, 2'(j)}];
        lane_b[j] = mix_q[{cm_half_q, 2'(j), cm_step_q}];
      end
`endif
    end
  end

  fnv_lane4 u_lane (
    .clk (clk),
    .rst (rst),
    .a   (lane_a),
    .b   (lane_b),
    .q   (lane_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q     <= '0;
      beat_q    <= '0;
      wr_mix_q  <= 1'b0;
      wr_beat_q <= '0;
    end else begin
      wr_mix_q  <= accept;
      wr_beat_q <= beat_q;
      if (state_q == ST_IDLE && bus.start) begin
        mix_q  <= bus.mix_in;
        beat_q <= '0;
      end else begin
        if (accept) beat_q <= beat_q + 1'b1;
        if (wr_mix_q) begin
          for (int j = 0; j < DAG_LANES; j++) begin
            mix_q[{wr_beat_q, 2'(j)}] <= lane_q[j];
          end
        end
      end
    end
  end

`ifdef FNV_CMIX_EN
  assign bus.cmix_out = cmix_q;

  // Halves alternate within a step so each step reads a result written the cycle before.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmix_q    <= '0;
      cm_step_q <= 2'd0;
      cm_half_q <= '0;
      wr_cmix_q <= 1'b0;
      wr_half_q <= '0;
    end else begin
      wr_cmix_q <= (state_q == ST_CMIX) && (cm_step_q != 2'd0);
      wr_half_q <= cm_half_q;
      if (state_q == ST_DRAIN) begin
        cm_step_q <= 2'd1;
        cm_half_q <= '0;
      end else if (state_q == ST_CMIX && cm_step_q != 2'd0) begin
        if (cm_half_q == LAST_HALF) begin
          cm_half_q <= '0;
          cm_step_q <= (cm_step_q == 2'd3) ? 2'd0 : cm_step_q + 2'd1;
        end else begin
          cm_half_q <= cm_half_q + 1'b1;
        end
      end
      if (wr_cmix_q) begin
        for (int j = 0; j < DAG_LANES; j++) begin
          cmix_q[{wr_half_q, 2'(j)}] <= lane_q[j];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fnv_mix_ctrl.sv
// tb/tb_fnv_mix_ctrl.sv - directed self-checking bench for fnv_mix_ctrl
module tb_fnv_mix_ctrl;

  localparam int NB = 8;
  localparam int MW = 4 * NB;
  localparam int MB = 32 * MW;
`ifdef FNV_CMIX_EN
  localparam int DONE_BASE = NB + 2 + 7;
`else
  localparam int DONE_BASE = NB + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  fnv_mix_ctrl_if #(.NUM_BEATS(NB)) bus ();

  fnv_mix_ctrl #(.NUM_BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] beat_word(input int k);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'(k * 16 + j);
    return r;
  endfunction

  // Cycle n counts clock edges after the one that samples start (start edge = cycle 0).
  task automatic run_pass(input logic [MB-1:0] init, input bit indexed, input logic [127:0] data,
                          input bit gaps, input bit poke_start, input int rst_at_beat,
                          output int done_cyc, output int beats);
    int n;
    bit fin;
    done_cyc = -1;
    beats    = 0;
    n        = 0;
    fin      = 1'b0;
    @(negedge clk);
    bus.mix_in    = init;
    bus.start     = 1'b1;
    bus.dag_valid = 1'b0;
    while (!fin && n < 200) begin
      @(negedge clk);
      n++;
      bus.start = poke_start && (n == 3);
      if (poke_start && n == 3) bus.mix_in = '1;
      if (bus.done) begin
        done_cyc = n;
        fin      = 1'b1;
      end else if (rst_at_beat >= 0 && beats == rst_at_beat) begin
        rst           = 1'b1;
        bus.dag_valid = 1'b1;
        bus.dag_data  = indexed ? beat_word(beats) : data;
        @(negedge clk);
        rst           = 1'b0;
        bus.dag_valid = 1'b0;
        fin           = 1'b1;
      end else begin
        bus.dag_valid = gaps ? (n % 2 == 1) : 1'b1;
        bus.dag_data  = indexed ? beat_word(beats) : data;
        if (bus.dag_valid && bus.dag_ready) beats++;
      end
    end
    bus.start     = 1'b0;
    bus.dag_valid = 1'b0;
    check("pass_bounded", MB'(fin), 1);
  endtask

  initial begin
    logic [MB-1:0] init_v, exp_v;
    int dc, nb;

    bus.start     = 1'b0;
    bus.mix_in    = '0;
    bus.dag_valid = 1'b0;
    bus.dag_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dag_ready", bus.dag_ready, 0);
    check("rst_mix_out", bus.mix_out, 0);
    rst = 1'b0;

    run_pass('0, 1'b0, '0, 1'b0, 1'b0, -1, dc, nb);
    check("zero_mix", bus.mix_out, '0);
    check("zero_done_cyc", dc, DONE_BASE);
    check("zero_beats", nb, NB);

    run_pass({MW{32'h1}}, 1'b0, '0, 1'b0, 1'b0, -1, dc, nb);
    check("ones_mix", bus.mix_out, {MW{32'h01000193}});
    check("ones_done_cyc", dc, DONE_BASE);
    @(negedge clk);
    check("done_pulse_low", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("mix_held", bus.mix_out, {MW{32'h01000193}});

    run_pass({MW{32'hFFFFFFFF}}, 1'b0, {4{32'h0000FFFF}}, 1'b1, 1'b0, -1, dc, nb);
    check("gap_mix", bus.mix_out, {MW{32'hFEFF0192}});
    check("gap_done_cyc", dc, DONE_BASE + 7);
    check("gap_beats", nb, NB);

    for (int i = 0; i < MW; i++) begin
      init_v[32*i +: 32] = 32'(i);
      exp_v[32*i +: 32]  = (32'(i) * 32'h01000193) ^ 32'((i / 4) * 16 + i % 4);
    end
    run_pass(init_v, 1'b1, '0, 1'b0, 1'b0, -1, dc, nb);
    check("idx_mix", bus.mix_out, exp_v);
    check("idx_word5", bus.mix_out[32*5 +: 32], 32'h050007CE);
    check("idx_word31", bus.mix_out[32*31 +: 32], 32'h1F0030BE);

    run_pass({MW{32'h1}}, 1'b0, '0, 1'b0, 1'b1, -1, dc, nb);
    check("restart_mix", bus.mix_out, {MW{32'h01000193}});
    check("restart_done_cyc", dc, DONE_BASE);
    check("restart_beats", nb, NB);

    run_pass({MW{32'h1}}, 1'b0, '0, 1'b0, 1'b0, 4, dc, nb);
    check("midrst_busy", bus.busy, 0);
    check("midrst_mix_out", bus.mix_out, 0);
    check("midrst_dag_ready", bus.dag_ready, 0);
    check("midrst_done", bus.done, 0);

    run_pass({MW{32'hFFFFFFFF}}, 1'b0, {4{32'h0000FFFF}}, 1'b0, 1'b0, -1, dc, nb);
    check("fresh_mix", bus.mix_out, {MW{32'hFEFF0192}});
    check("fresh_done_cyc", dc, DONE_BASE);

`ifdef FNV_CMIX_EN
    run_pass('0, 1'b0, {32'd5, 96'd0}, 1'b0, 1'b0, -1, dc, nb);
    check("cmix_mix", bus.mix_out, {NB{32'd5, 32'd0, 32'd0, 32'd0}});
    check("cmix_out", MB'(bus.cmix_out), MB'({NB{32'd5}}));
    check("cmix_done_cyc", dc, NB + 2 + 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
